// File: rtl/demux_rr.sv
// -----------------------------------------------------------------------------
// demux_rr
//
// Registered 1:4 demultiplexer for the receive side of a lane-serialised link.
// One input stream is steered onto lanes a..d, either by the explicit `sel`
// input or by an internal round-robin counter. The round-robin path rebuilds a
// frame of four beats and pulses `frame_done` on the last one.
//
// Build option:
//   DEMUX_HOLD_EN  defined   : each lane holds its last written value.
//                  undefined : lane data is valid only while its *_vld is high
//                              and reads 0 in every other cycle.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_data      data beat to route (WIDTH bits)
//   in_valid     beat present this cycle
//   mode         0 = explicit (sel), 1 = round-robin
//   sel          explicit lane select: 00 a, 01 b, 10 c, 11 d
//   flush        synchronous clear of the counter and frame state; drops a
//                beat presented in the same cycle
//   a..d         registered lane outputs (WIDTH bits each)
//   a_vld..d_vld one-cycle pulse when the lane was written
//   frame_done   one-cycle pulse with the fourth round-robin beat
//   cur_ch       lane the next round-robin beat will target
// -----------------------------------------------------------------------------
module demux_rr #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             mode,
    input  logic [1:0]       sel,
    input  logic             flush,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic             a_vld,
    output logic             b_vld,
    output logic             c_vld,
    output logic             d_vld,
    output logic             frame_done,
    output logic [1:0]       cur_ch
);

    // state   | meaning
    // --------+-------------------------------------------------------------
    // IDLE    | no frame open; cur_ch = 0; mode is sampled on the next beat
    // COLLECT | round-robin frame open; beats go to cur_ch, mode is ignored
    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t     state;
    logic       rr_beat;
    logic [1:0] lane_sel;

    // The mode "latch" is the state itself: COLLECT is only ever entered from
    // a round-robin beat, so being in COLLECT means round-robin until the
    // frame closes, whatever `mode` does meanwhile.
    always_comb begin
        rr_beat  = (state == COLLECT) || mode;
        lane_sel = rr_beat ? cur_ch : sel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cur_ch     <= 2'd0;
            a          <= '0;
            b          <= '0;
            c          <= '0;
            d          <= '0;
            a_vld      <= 1'b0;
            b_vld      <= 1'b0;
            c_vld      <= 1'b0;
            d_vld      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            a_vld      <= 1'b0;
            b_vld      <= 1'b0;
            c_vld      <= 1'b0;
            d_vld      <= 1'b0;
            frame_done <= 1'b0;
`ifndef DEMUX_HOLD_EN
            // Pulse-data build: lanes return to 0 unless written this edge.
            a <= '0;
            b <= '0;
            c <= '0;
            d <= '0;
`endif
            if (flush) begin
                state  <= IDLE;
                cur_ch <= 2'd0;
            end else if (in_valid) begin
                unique case (lane_sel)
                    2'd0: begin a <= in_data; a_vld <= 1'b1; end
                    2'd1: begin b <= in_data; b_vld <= 1'b1; end
                    2'd2: begin c <= in_data; c_vld <= 1'b1; end
                    2'd3: begin d <= in_data; d_vld <= 1'b1; end
                endcase
                if (rr_beat) begin
                    if (cur_ch == 2'd3) begin
                        frame_done <= 1'b1;
                        cur_ch     <= 2'd0;
                        state      <= IDLE;
                    end else begin
                        cur_ch     <= cur_ch + 2'd1;
                        state      <= COLLECT;
                    end
                end
            end
        end
    end

endmodule
